xeng_window_sched: RTL and testbench
====================================

Name: xeng_window_sched

Overview:
- Schedules antenna windows from an upstream ping-pong window buffer into the X-engine.
- Arbitrates strictly alternating between the two buffers and issues BRAM read addresses (antenna-major, SERIAL_ACC_LEN samples per antenna).
- Generates the X-engine sync, vld and mcnt, aligned to the BRAM read latency, and releases each buffer once its last sample has left the BRAM.

Parameters:
- SERIAL_ACC_LEN_BITS, 8, log2 samples per antenna per window (must match the X-engine)
- N_ANTS_BITS, 5, log2 dual-pol antenna count (N_ANTS=32)
- BRAM_LATENCY, 2, read-address to data latency of the window buffer
- MCNT_WIDTH, 48, mcnt timestamp width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  scheduler enable
- win_rdy  in  2  per-buffer window-full flag; held until win_rel
- win_mcnt  in  2*MCNT_WIDTH  per-buffer mcnt; buffer b at [b*MCNT_WIDTH +: MCNT_WIDTH]
- win_rel  out  2  one-cycle release pulse per buffer
- rd_buf  out  1  buffer being read
- rd_addr  out  N_ANTS_BITS+SERIAL_ACC_LEN_BITS  {antenna, sample} read address
- rd_en  out  1  read strobe
- xeng_sync  out  1  sync to the X-engine
- xeng_vld  out  1  valid to the X-engine, coincident with BRAM data out
- xeng_mcnt  out  MCNT_WIDTH  mcnt to the X-engine
- busy  out  1  high outside IDLE
- seq_err  out  1  sticky sequence error

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, expected buffer exp=0, all outputs 0 (win_rel, rd_buf, rd_addr, rd_en, xeng_sync, xeng_vld, xeng_mcnt, busy, seq_err). All delay-line stages clear.
- Reset mid-window: the window is abandoned with no win_rel for it. After rst_n rises, scheduling resumes from buffer 0.
- Window length W = 2^(N_ANTS_BITS+SERIAL_ACC_LEN_BITS) read cycles. The address counter increments the sample index fastest; the antenna index steps every 2^SERIAL_ACC_LEN_BITS cycles.
- States:
  - IDLE: wait for en && win_rdy[exp], then go to SYNC.
  - SYNC (1 cycle): rd_buf<=exp; latch win_mcnt[exp]; assert internal sync; rd_en=0; go to RUN.
  - RUN (W cycles): rd_en=1, rd_addr counts 0..W-1.
    - On the last address, if en && win_rdy[~exp], go to SYNC.
    - Otherwise go to IDLE.
    - exp toggles on leaving RUN.
- Back-to-back windows have exactly one vld-low cycle (the SYNC cycle) between them.
- en deassert mid-window: the current window completes, then the scheduler returns to IDLE. Windows are never truncated.
- Output alignment:
  - xeng_vld = rd_en delayed BRAM_LATENCY cycles.
  - xeng_sync = internal sync delayed BRAM_LATENCY cycles, so it is high in the cycle before the first xeng_vld of each window.
  - xeng_mcnt updates with xeng_sync and holds until the next sync.
- win_rel[b] pulses in the cycle xeng_vld carries the last sample of buffer b. That is BRAM_LATENCY cycles after the last rd_en.
- win_rdy changes during RUN are ignored.
- seq_err: set when in IDLE with en=1, win_rdy[~exp]=1 and win_rdy[exp]=0. The scheduler keeps waiting on exp and never skips. seq_err clears only on reset.
- Simultaneous win_rdy[0] and win_rdy[1] in IDLE: take exp. This is not an error.
- Address and counter arithmetic is unsigned and wraps modulo W. No other wrap conditions exist.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SYNC, RUN};
  - localparams W and ADDR_WIDTH;
  - the function deriving the buffer-release delay from BRAM_LATENCY.
- One sub-module, sched_delay_line: a parameterised shift register (WIDTH, DELAY, reset to 0). It is used for the {sync, vld, last, buf} alignment with BRAM_LATENCY.

Test Plan (SERIAL_ACC_LEN_BITS=2, N_ANTS_BITS=2, BRAM_LATENCY=2, W=16):
- Reset, then en=1 and win_rdy=01 with mcnt0=0x10:
  - rd_en high for 16 cycles with rd_addr 0..15 and rd_buf=0;
  - xeng_sync one cycle before 16 xeng_vld cycles;
  - xeng_mcnt=0x10;
  - win_rel=01 on the last vld cycle.
- Both buffers ready, mcnt1=0x20, en held:
  - second window starts with exactly one vld-low gap;
  - rd_buf=1, xeng_mcnt=0x20, win_rel=10.
- win_rdy=10 only, from reset:
  - seq_err=1 next cycle;
  - no rd_en until win_rdy[0]=1, then buffer 0 is read first.
- en dropped at address 5 of a window:
  - the window completes all 16 reads;
  - returns to IDLE and busy=0 BRAM_LATENCY-independent, one cycle after the last read.
- rst_n pulsed low at address 7:
  - all outputs 0 asynchronously;
  - no win_rel for that window;
  - restart reads buffer 0 from address 0.
- Re-run the first scenario with BRAM_LATENCY=4: xeng_vld lags rd_en by exactly 4 cycles.

Source files
------------

// File: rtl/xeng_window_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : xeng_window_sched_pkg
// Purpose : Shared types and helpers for the X-engine window scheduler.
//           - state_e       : scheduler state encoding
//           - ADDR_WIDTH, W : default read-address width and window length
//           - addr_width()  : {antenna, sample} address width
//           - rel_delay()   : buffer-release delay from the BRAM read latency
// Revision: 1.0 - initial release
// ============================================================================
package xeng_window_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Defaults matching the top-level parameter defaults.
  localparam int ADDR_WIDTH = 8 + 5;
  localparam int W          = 1 << ADDR_WIDTH;

  function automatic int addr_width(input int serial_acc_len_bits, input int n_ants_bits);
    return serial_acc_len_bits + n_ants_bits;
  endfunction

  // The release flag travels in the same delay line as vld, so the pulse
  // lines up with the last sample leaving the BRAM.
  function automatic int rel_delay(input int bram_latency);
    return bram_latency;
  endfunction

endpackage
`default_nettype wire

// File: rtl/xeng_window_sched_delay_line.sv
`default_nettype none
// ============================================================================
// Module  : sched_delay_line
// Purpose : Parameterised shift register, all stages reset to zero.
// Ports   : clk, rst_n (async active-low)
//           din  [WIDTH-1:0]  input word
//           dout [WIDTH-1:0]  din delayed by DELAY cycles (DELAY=0: bypass)
// Revision: 1.0 - initial release
// ============================================================================
module sched_delay_line #(
  parameter int WIDTH = 1,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DELAY == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DELAY];
      logic [WIDTH-1:0] stage_d [DELAY];

      always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DELAY; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DELAY; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          for (int i = 0; i < DELAY; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign dout = stage_q[DELAY-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/xeng_window_sched.sv
`default_nettype none
// ============================================================================
// Module  : xeng_window_sched
// Purpose : Reads antenna windows out of a ping-pong window buffer into the
//           X-engine, strictly alternating buffers, and generates the
//           X-engine sync/vld/mcnt aligned to the BRAM read latency.
// Ports   : clk, rst_n (async active-low), en
//           win_rdy[1:0], win_mcnt[2*MCNT_WIDTH-1:0]  upstream buffer status
//           win_rel[1:0]                              release pulse per buffer
//           rd_buf, rd_addr, rd_en                    BRAM read side
//           xeng_sync, xeng_vld, xeng_mcnt            X-engine side
//           busy, seq_err                             status
// Revision: 1.0 - initial release
// ============================================================================
module xeng_window_sched
  import xeng_window_sched_pkg::*;
#(
  parameter int SERIAL_ACC_LEN_BITS = 8,
  parameter int N_ANTS_BITS         = 5,
  parameter int BRAM_LATENCY        = 2,
  parameter int MCNT_WIDTH          = 48
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en,
  input  logic [1:0]                            win_rdy,
  input  logic [2*MCNT_WIDTH-1:0]               win_mcnt,
  output logic [1:0]                            win_rel,
  output logic                                  rd_buf,
  output logic [N_ANTS_BITS+SERIAL_ACC_LEN_BITS-1:0] rd_addr,
  output logic                                  rd_en,
  output logic                                  xeng_sync,
  output logic                                  xeng_vld,
  output logic [MCNT_WIDTH-1:0]                 xeng_mcnt,
  output logic                                  busy,
  output logic                                  seq_err
);

  localparam int AW      = addr_width(SERIAL_ACC_LEN_BITS, N_ANTS_BITS);
  localparam int REL_DLY = rel_delay(BRAM_LATENCY);
  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_e                state_q, state_d;
  logic                  exp_q, exp_d;
  logic                  rd_buf_q, rd_buf_d;
  logic                  rd_en_q, rd_en_d;
  logic                  sync_q, sync_d;
  logic                  seq_err_q, seq_err_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [MCNT_WIDTH-1:0] mcnt_lat_q, mcnt_lat_d;
  logic [MCNT_WIDTH-1:0] mcnt_hold_q, mcnt_hold_d;

  logic                  alt_buf;
  logic                  last_rd;
  logic [MCNT_WIDTH-1:0] mcnt_exp;
  logic [MCNT_WIDTH-1:0] mcnt_alt;
  logic                  dly_sync, dly_vld, dly_last, dly_buf;

  assign alt_buf  = ~exp_q;
  assign last_rd  = rd_en_q && (addr_q == LAST_ADDR);
  assign mcnt_exp = exp_q ? win_mcnt[2*MCNT_WIDTH-1:MCNT_WIDTH] : win_mcnt[MCNT_WIDTH-1:0];
  assign mcnt_alt = exp_q ? win_mcnt[MCNT_WIDTH-1:0] : win_mcnt[2*MCNT_WIDTH-1:MCNT_WIDTH];

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    rd_buf_d   = rd_buf_q;
    rd_en_d    = rd_en_q;
    sync_d     = sync_q;
    seq_err_d  = seq_err_q;
    addr_d     = addr_q;
    mcnt_lat_d = mcnt_lat_q;

    case (state_q)
      IDLE: begin
        if (en && win_rdy[exp_q]) begin
          state_d    = SYNC;
          sync_d     = 1'b1;
          rd_buf_d   = exp_q;
          mcnt_lat_d = mcnt_exp;
        end else if (en && win_rdy[alt_buf]) begin
          // The other buffer filled first: flag it, but keep waiting on exp.
          seq_err_d = 1'b1;
        end
      end
      SYNC: begin
        state_d = RUN;
        sync_d  = 1'b0;
        rd_en_d = 1'b1;
        addr_d  = '0;
      end
      RUN: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == LAST_ADDR) begin
          exp_d   = alt_buf;
          rd_en_d = 1'b0;
          if (en && win_rdy[alt_buf]) begin
            state_d    = SYNC;
            sync_d     = 1'b1;
            rd_buf_d   = alt_buf;
            mcnt_lat_d = mcnt_alt;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sync_d  = 1'b0;
        rd_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      exp_q       <= 1'b0;
      rd_buf_q    <= 1'b0;
      rd_en_q     <= 1'b0;
      sync_q      <= 1'b0;
      seq_err_q   <= 1'b0;
      addr_q      <= '0;
      mcnt_lat_q  <= '0;
      mcnt_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      rd_buf_q    <= rd_buf_d;
      rd_en_q     <= rd_en_d;
      sync_q      <= sync_d;
      seq_err_q   <= seq_err_d;
      addr_q      <= addr_d;
      mcnt_lat_q  <= mcnt_lat_d;
      mcnt_hold_q <= mcnt_hold_d;
    end
  end

  sched_delay_line #(
    .WIDTH (4),
    .DELAY (REL_DLY)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({sync_q, rd_en_q, last_rd, rd_buf_q}),
    .dout  ({dly_sync, dly_vld, dly_last, dly_buf})
  );

  // mcnt_lat_q is not overwritten until the next SYNC, at least W+1 cycles
  // later, so it is still valid when the delayed sync arrives. Presenting it
  // in the sync cycle itself makes xeng_mcnt change together with xeng_sync.
  assign mcnt_hold_d = dly_sync ? mcnt_lat_q : mcnt_hold_q;

  assign win_rel   = {dly_last & dly_buf, dly_last & ~dly_buf};
  assign rd_buf    = rd_buf_q;
  assign rd_addr   = addr_q;
  assign rd_en     = rd_en_q;
  assign xeng_sync = dly_sync;
  assign xeng_vld  = dly_vld;
  assign xeng_mcnt = mcnt_hold_d;
  assign busy      = (state_q != IDLE);
  assign seq_err   = seq_err_q;

endmodule
`default_nettype wire

// File: tb/tb_xeng_window_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_xeng_window_sched
// Purpose : Self-checking bench for xeng_window_sched. Two instances share
//           one stimulus stream: BRAM_LATENCY=2 and BRAM_LATENCY=4, with
//           W=16. A window-level reference model predicts every output.
// Revision: 1.0 - initial release
// ============================================================================
module tb_xeng_window_sched;

  localparam int SAL = 2;
  localparam int NA  = 2;
  localparam int AW  = SAL + NA;
  localparam int W   = 1 << AW;
  localparam int MW  = 48;
  localparam int LA  = 2;
  localparam int LB  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    win_rdy;
  logic [2*MW-1:0] win_mcnt;

  logic [1:0]    rel_a, rel_b;
  logic          buf_a, buf_b;
  logic [AW-1:0] addr_a, addr_b;
  logic          rden_a, rden_b;
  logic          sync_a, sync_b;
  logic          vld_a, vld_b;
  logic [MW-1:0] mcnt_a, mcnt_b;
  logic          busy_a, busy_b;
  logic          err_a, err_b;

  always #5 clk = ~clk;

  xeng_window_sched #(
    .SERIAL_ACC_LEN_BITS (SAL), .N_ANTS_BITS (NA), .BRAM_LATENCY (LA), .MCNT_WIDTH (MW)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .en (en), .win_rdy (win_rdy), .win_mcnt (win_mcnt),
    .win_rel (rel_a), .rd_buf (buf_a), .rd_addr (addr_a), .rd_en (rden_a),
    .xeng_sync (sync_a), .xeng_vld (vld_a), .xeng_mcnt (mcnt_a),
    .busy (busy_a), .seq_err (err_a)
  );

  xeng_window_sched #(
    .SERIAL_ACC_LEN_BITS (SAL), .N_ANTS_BITS (NA), .BRAM_LATENCY (LB), .MCNT_WIDTH (MW)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .en (en), .win_rdy (win_rdy), .win_mcnt (win_mcnt),
    .win_rel (rel_b), .rd_buf (buf_b), .rd_addr (addr_b), .rd_en (rden_b),
    .xeng_sync (sync_b), .xeng_vld (vld_b), .xeng_mcnt (mcnt_b),
    .busy (busy_b), .seq_err (err_b)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: m_pos = -1 idle, 0 sync cycle, 1..W reading sample m_pos-1.
  int            m_pos;
  bit            m_exp, m_buf, m_err;
  logic [MW-1:0] m_mcnt;
  int            cyc;
  // Per-cycle history of the un-delayed events, used to predict delayed outputs.
  bit            h_sync [8];
  bit            h_rden [8];
  bit            h_last [8];
  bit            h_buf  [8];
  logic [MW-1:0] h_mcnt [8];
  logic [MW-1:0] held_a, held_b;

  function automatic logic [MW-1:0] mc(input bit b);
    return b ? win_mcnt[2*MW-1:MW] : win_mcnt[MW-1:0];
  endfunction

  task automatic model_reset();
    m_pos  = -1;
    m_exp  = 1'b0;
    m_buf  = 1'b0;
    m_err  = 1'b0;
    m_mcnt = '0;
    held_a = '0;
    held_b = '0;
    for (int i = 0; i < 8; i++) begin
      h_sync[i] = 1'b0; h_rden[i] = 1'b0; h_last[i] = 1'b0; h_buf[i] = 1'b0; h_mcnt[i] = '0;
    end
  endtask

  task automatic start_window(input bit b);
    m_pos  = 0;
    m_buf  = b;
    m_mcnt = mc(b);
  endtask

  task automatic model_step();
    int k, ka, kb;
    if (m_pos < 0) begin
      if (en && win_rdy[m_exp])       start_window(m_exp);
      else if (en && win_rdy[!m_exp]) m_err = 1'b1;
    end else if (m_pos < W) begin
      m_pos++;
    end else begin
      m_exp = !m_exp;
      if (en && win_rdy[m_exp]) start_window(m_exp);
      else                      m_pos = -1;
    end
    cyc++;
    k = cyc % 8;
    h_sync[k] = (m_pos == 0);
    h_rden[k] = (m_pos >= 1);
    h_last[k] = (m_pos == W);
    h_buf[k]  = m_buf;
    h_mcnt[k] = m_mcnt;
    ka = (cyc + 8 - LA) % 8;
    kb = (cyc + 8 - LB) % 8;
    if (h_sync[ka]) held_a = h_mcnt[ka];
    if (h_sync[kb]) held_b = h_mcnt[kb];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic chk_one(input string p, input int lat, input logic [1:0] rel, input logic bv,
                         input logic [AW-1:0] addr, input logic rden, input logic sync,
                         input logic vld, input logic [MW-1:0] mcnt, input logic busy,
                         input logic err, input logic [MW-1:0] held);
    int  k;
    logic [1:0] rel_exp;
    k = (cyc + 8 - lat) % 8;
    rel_exp = h_last[k] ? (h_buf[k] ? 2'b10 : 2'b01) : 2'b00;
    chk({p, ".rd_en"}, 64'(rden), 64'(m_pos >= 1));
    if (m_pos >= 1) begin
      chk({p, ".rd_addr"}, 64'(addr), 64'(m_pos - 1));
      chk({p, ".rd_buf"}, 64'(bv), 64'(m_buf));
    end
    if (!rst_n) begin
      chk({p, ".rst_rd_addr"}, 64'(addr), 64'd0);
      chk({p, ".rst_rd_buf"}, 64'(bv), 64'd0);
    end
    chk({p, ".busy"}, 64'(busy), 64'(m_pos >= 0));
    chk({p, ".seq_err"}, 64'(err), 64'(m_err));
    chk({p, ".xeng_vld"}, 64'(vld), 64'(h_rden[k]));
    chk({p, ".xeng_sync"}, 64'(sync), 64'(h_sync[k]));
    chk({p, ".xeng_mcnt"}, 64'(mcnt), 64'(held));
    chk({p, ".win_rel"}, 64'(rel), 64'(rel_exp));
  endtask

  task automatic check_all();
    chk_one("lat2", LA, rel_a, buf_a, addr_a, rden_a, sync_a, vld_a, mcnt_a, busy_a, err_a, held_a);
    chk_one("lat4", LB, rel_b, buf_b, addr_b, rden_b, sync_b, vld_b, mcnt_b, busy_b, err_b, held_b);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Advance until the model is reading the given address (bounded).
  task automatic run_to_addr(input int a, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 4 * W && !found; i++) begin
      if (m_pos == a + 1) found = 1'b1;
      else                tick();
    end
    chk(tag, 64'(found), 64'd1);
  endtask

  initial begin
    logic [63:0] rnd;
    cyc      = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    win_rdy  = 2'b00;
    win_mcnt = '0;
    #1;
    model_reset();
    check_all();
    tick();
    tick();
    rst_n = 1'b1;

    // First window on buffer 0, then both ready for a back-to-back window.
    win_mcnt = {48'h20, 48'h10};
    en       = 1'b1;
    win_rdy  = 2'b01;
    repeat (4) tick();
    win_rdy = 2'b11;
    repeat (20) tick();
    win_rdy = 2'b00;
    repeat (20) tick();

    // Wrong buffer first from reset: error flagged, buffer 0 still taken first.
    async_reset();
    win_mcnt = {48'h2b, 48'h1a};
    win_rdy  = 2'b10;
    repeat (5) tick();
    win_rdy = 2'b11;
    repeat (8) tick();

    // Drop enable mid-window: the window completes, then idle.
    run_to_addr(5, "reach_addr5");
    en = 1'b0;
    repeat (2 * W) tick();

    // Reset mid-window at address 7: abandoned, restart from buffer 0.
    en      = 1'b1;
    win_rdy = 2'b11;
    run_to_addr(7, "reach_addr7");
    async_reset();
    repeat (2 * W + 8) tick();

    // Randomised traffic: buffers fill (new mcnt) and drain, en mostly high.
    win_rdy = 2'b00;
    for (int n = 0; n < 1500; n++) begin
      en = ($urandom_range(0, 9) != 0);
      for (int b = 0; b < 2; b++) begin
        if (!win_rdy[b] && $urandom_range(0, 3) == 0) begin
          rnd = {$urandom, $urandom};
          win_rdy[b] = 1'b1;
          win_mcnt[b*MW +: MW] = rnd[MW-1:0];
        end else if (win_rdy[b] && $urandom_range(0, 29) == 0) begin
          win_rdy[b] = 1'b0;
        end
      end
      if ($urandom_range(0, 399) == 0) async_reset();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
